debounce_multi: RTL and testbench

- Parametrised, multi-channel debouncer and edge detector for buttons, switches and other slow asynchronous inputs.
- Each channel has a 2-FF synchroniser, optional polarity inversion and a stability counter clocked by a slow sample-enable tick.
- Each channel outputs a registered debounced level plus one-Clk-wide rise and fall pulses.
- Sits between board pins and SoC control logic. It generalises the simple two-flop pulse debouncer to N channels, with a programmable stability window and both edge directions.

---
 rtl/debounce_multi.sv | 84 ++++++++
 tb/tb_debounce_multi.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: 2-FF synchroniser, stability counter on a slow
// sample tick, registered level plus one-cycle rise/fall pulses per channel.
module debounce_multi #(
    parameter int                  CHANNELS   = 4,
    parameter int                  STABLE_CNT = 4,
    parameter logic [CHANNELS-1:0] INVERT     = {CHANNELS{1'b0}},
    parameter int                  CNT_W      = $clog2(STABLE_CNT)
) (
    input  logic                Clk,
    input  logic                reset_n,
    input  logic                tick_en,
    input  logic [CHANNELS-1:0] in_raw,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_change
);

    localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(STABLE_CNT - 1);

    logic [CHANNELS-1:0]            w_norm;
    logic [CHANNELS-1:0]            r_sync1;
    logic [CHANNELS-1:0]            r_sync2;
    logic [CHANNELS-1:0]            r_level;
    logic [CHANNELS-1:0]            r_rise;
    logic [CHANNELS-1:0]            r_fall;
    logic [CHANNELS-1:0][CNT_W-1:0] r_cnt;

    logic [CHANNELS-1:0]            w_mismatch;
    logic [CHANNELS-1:0]            w_commit;
    logic [CHANNELS-1:0][CNT_W-1:0] w_cnt_nxt;

    assign w_norm = in_raw ^ INVERT;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_norm;
            r_sync2 <= r_sync1;
        end
    end

    // A channel's count only survives while the synced input disagrees
    // with the accepted level, so any glitch shorter than the window is lost.
    always_comb begin
        w_mismatch = r_sync2 ^ r_level;
        w_commit   = '0;
        w_cnt_nxt  = r_cnt;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!w_mismatch[i]) begin
                w_cnt_nxt[i] = '0;
            end else if (tick_en) begin
                if (r_cnt[i] == LP_CNT_MAX) begin
                    w_commit[i]  = 1'b1;
                    w_cnt_nxt[i] = '0;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_level <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_level <= r_level ^ w_commit;
            r_rise  <= w_commit & r_sync2;
            r_fall  <= w_commit & ~r_sync2;
        end
    end

    assign level      = r_level;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign any_change = |(r_rise | r_fall);

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: latency, glitch rejection, slow ticks,
// inversion, simultaneous commits and mid-count reset.
module tb_debounce_multi;

    logic       Clk = 1'b0;
    logic       reset_n;
    logic       tick_en;
    logic [3:0] in_raw;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any_change;
    logic [3:0] in_inv;
    logic [3:0] level_i;
    logic [3:0] rise_i;
    logic [3:0] fall_i;
    logic       any_i;

    int n_tests = 0;
    int n_fail  = 0;

    debounce_multi #(
        .CHANNELS  (4),
        .STABLE_CNT(4),
        .INVERT    (4'b0000)
    ) dut (
        .Clk       (Clk),
        .reset_n   (reset_n),
        .tick_en   (tick_en),
        .in_raw    (in_raw),
        .level     (level),
        .rise      (rise),
        .fall      (fall),
        .any_change(any_change)
    );

    debounce_multi #(
        .CHANNELS  (4),
        .STABLE_CNT(4),
        .INVERT    (4'b0001)
    ) dut_inv (
        .Clk       (Clk),
        .reset_n   (reset_n),
        .tick_en   (tick_en),
        .in_raw    (in_inv),
        .level     (level_i),
        .rise      (rise_i),
        .fall      (fall_i),
        .any_change(any_i)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        tick_en = 1'b1;
        in_raw  = 4'b0000;
        in_inv  = 4'b0001;
        repeat (3) step();
        chk("rst_out", {level, rise, fall, any_change}, 0);
        chk("rst_inv", {level_i, rise_i, fall_i, any_i}, 0);

        reset_n = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            chk("idle_out", {level, rise, fall, any_change}, 0);
            chk("idle_inv", {level_i, rise_i, fall_i, any_i}, 0);
        end

        // ch0 rises: accepted on edge 6 only
        in_raw[0] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            chk("ch0_rise", rise, (e == 6) ? 4'b0001 : 4'b0000);
            chk("ch0_lvl", level, (e >= 6) ? 4'b0001 : 4'b0000);
            chk("ch0_any", any_change, (e == 6) ? 1 : 0);
        end

        in_raw[1] = 1'b1;
        repeat (3) step();
        in_raw[1] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk("glitch_lvl", level, 4'b0001);
            chk("glitch_pulse", rise | fall, 4'b0000);
        end
        chk("glitch_cnt", dut.r_cnt[1], 0);

        in_raw[1] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            chk("ch1_rise", rise, (e == 6) ? 4'b0010 : 4'b0000);
            chk("ch1_lvl", level, (e >= 6) ? 4'b0011 : 4'b0001);
        end

        in_raw[2] = 1'b1;
        repeat (6) step();
        chk("ch2_set", level, 4'b0111);
        step();

        // Ticks every 8th edge: mismatch from edge 3, commit at 4th tick
        in_raw[2] = 1'b0;
        for (int e = 1; e <= 34; e++) begin
            tick_en = (e % 8 == 0);
            step();
            chk("slow_fall", fall, (e == 32) ? 4'b0100 : 4'b0000);
            chk("slow_lvl", level, (e >= 32) ? 4'b0011 : 4'b0111);
            if (e == 7)  chk("slow_cnt7", dut.r_cnt[2], 0);
            if (e == 12) chk("slow_cnt12", dut.r_cnt[2], 1);
            if (e == 20) chk("slow_cnt20", dut.r_cnt[2], 2);
        end
        tick_en = 1'b1;

        in_inv[0] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            chk("inv_rise", rise_i, (e == 6) ? 4'b0001 : 4'b0000);
            chk("inv_lvl", level_i, (e >= 6) ? 4'b0001 : 4'b0000);
        end

        in_raw[0] = 1'b0;
        repeat (8) step();
        chk("ch0_drop", level, 4'b0010);

        in_raw[0] = 1'b1;
        in_raw[3] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            chk("dual_rise", rise, (e == 6) ? 4'b1001 : 4'b0000);
            chk("dual_fall", fall, 4'b0000);
            chk("dual_any", any_change, (e == 6) ? 1 : 0);
        end
        chk("dual_lvl", level, 4'b1011);

        in_raw[3] = 1'b0;
        repeat (3) step();
        chk("mid_cnt", dut.r_cnt[3], 1);
        chk("mid_lvl", level, 4'b1011);
        reset_n = 1'b0;
        #1;
        chk("async_rst", {level, rise, fall, any_change}, 0);
        chk("async_cnt", dut.r_cnt[3], 0);
        in_raw = 4'b0000;
        repeat (2) step();
        reset_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            chk("post_rst", {level, rise, fall, any_change}, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
